// File: rtl/banked_memory.sv
// rtl/banked_memory.sv - single-port word array with boot-image initialisation and registered reads
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      asynchronous assert, active-low; release is synchronised internally
//   req        access request, honoured only while ready=1
//   we         1 = write, 0 = read (qualified by req)
//   addr       word address, full range 0..DEPTH-1
//   wdata      write data
//   ready      high in IDLE, when requests are accepted
//   rdata      registered read data, held until the next accepted read
//   rvalid     one-cycle pulse the cycle after an accepted read
//   init_done  high once the array has been initialised

module banked_memory #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int PRELOAD = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              init_done
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] BOOT_LEN = (ADDR_W + 1)'(9);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W:0]   init_cnt;
    logic              init_wr;
    logic              sync_meta;
    logic              sync_run;
    logic [7:0]        boot_byte;
    logic [DATA_W-1:0] init_data;
    logic              acc_rd;
    logic              acc_wr;

    logic [DATA_W-1:0] mem [DEPTH];

    // Assertion is immediate; release reaches the FSM only after two flops,
    // so INIT writes start once sync_run rises.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b0;
            sync_run  <= 1'b0;
        end else begin
            sync_meta <= 1'b1;
            sync_run  <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state <= next_state;
            if (init_wr) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        init_wr    = 1'b0;
        case (state)
            ST_INIT: begin
                if (sync_run) begin
                    init_wr = 1'b1;
                    if (init_cnt == CNT_LAST) begin
                        next_state = ST_IDLE;
                    end
                end
            end
            ST_IDLE: next_state = ST_IDLE;
            default: next_state = ST_INIT;
        endcase
    end

    // Boot image occupies the first nine words; everything else is zero.
    always_comb begin
        boot_byte = 8'h00;
        case (init_cnt[3:0])
            4'd0:    boot_byte = 8'h40;
            4'd1:    boot_byte = 8'h0A;
            4'd2:    boot_byte = 8'h60;
            4'd3:    boot_byte = 8'h05;
            4'd4:    boot_byte = 8'h00;
            4'd5:    boot_byte = 8'h80;
            4'd6:    boot_byte = 8'h08;
            4'd7:    boot_byte = 8'hE0;
            default: boot_byte = 8'h00;
        endcase
    end

    always_comb begin
        init_data = '0;
        if (PRELOAD != 0 && init_cnt < BOOT_LEN) begin
            init_data = DATA_W'(boot_byte);
        end
    end

    assign ready     = (state == ST_IDLE);
    assign init_done = (state == ST_IDLE);
    assign acc_rd    = ready && req && !we;
    assign acc_wr    = ready && req && we;

    // Array has no reset: contents come only from INIT and accepted writes.
    always_ff @(posedge clk) begin
        if (init_wr) begin
            mem[init_cnt[ADDR_W-1:0]] <= init_data;
        end else if (acc_wr) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= acc_rd;
            if (acc_rd) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule
